// File: rtl/psw_flag_unit.sv
// rtl/psw_flag_unit.sv - PSW flag register with carry feedback and interrupt shadow stack
// Optional shadow stack is built only when PSW_SHADOW_EN is defined.
module psw_flag_unit #(
  parameter int WIDTH     = 16,
  parameter int STK_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Sum,
  input  logic             Cout,
  input  logic             A_msb,
  input  logic             B_msb,
  input  logic             ALUop,
  input  logic             flag_we,
  input  logic [3:0]       flag_mask,
  input  logic             psw_wr,
  input  logic [WIDTH-1:0] psw_din,
  input  logic             setc,
  input  logic             clrc,
  input  logic             int_save,
  input  logic             int_restore,
  output logic             PSW_C,
  output logic             PSW_Z,
  output logic             PSW_N,
  output logic             PSW_V,
  output logic             PSW_IE,
  output logic [WIDTH-1:0] psw_dout,
  output logic [2:0]       stk_cnt,
  output logic             stk_err
);

  logic c_q, z_q, n_q, v_q, ie_q;
  logic c_d, z_d, n_d, v_d, ie_d;
  logic bx, alu_c, alu_z, alu_n, alu_v;
  logic [4:0] psw_cur;
  logic unused_din;

  assign psw_cur    = {ie_q, v_q, n_q, z_q, c_q};
  assign unused_din = ^psw_din[WIDTH-2:5];

  // Subtract feeds ~B into the adder, so overflow must see the inverted sign bit.
  assign bx    = ALUop ? ~B_msb : B_msb;
  assign alu_c = Cout;
  assign alu_z = (Sum == '0);
  assign alu_n = Sum[WIDTH-1];
  assign alu_v = (A_msb == bx) && (Sum[WIDTH-1] != A_msb);

`ifdef PSW_SHADOW_EN
  logic [4:0] stk_q [4];
  logic [2:0] stk_cnt_q, stk_cnt_d;
  logic       stk_err_q, stk_err_d;
  logic       push_en;
  logic [1:0] push_idx, pop_idx;

  assign push_idx = stk_cnt_q[1:0];
  assign pop_idx  = 2'(stk_cnt_q - 3'd1);
`else
  logic unused_shadow;
  assign unused_shadow = int_restore ^ psw_din[WIDTH-1];
`endif

  always_comb begin
    c_d  = c_q;
    z_d  = z_q;
    n_d  = n_q;
    v_d  = v_q;
    ie_d = ie_q;
`ifdef PSW_SHADOW_EN
    stk_cnt_d = stk_cnt_q;
    stk_err_d = stk_err_q;
    push_en   = 1'b0;
    if (int_restore) begin
      if (stk_cnt_q != 3'd0) begin
        {ie_d, v_d, n_d, z_d, c_d} = stk_q[pop_idx];
        stk_cnt_d = stk_cnt_q - 3'd1;
      end else begin
        stk_err_d = 1'b1;
      end
    end else if (int_save) begin
      ie_d = 1'b0;
      if (stk_cnt_q < 3'(STK_DEPTH)) begin
        push_en   = 1'b1;
        stk_cnt_d = stk_cnt_q + 3'd1;
      end else begin
        stk_err_d = 1'b1;
      end
    end else
`else
    if (int_save) begin
      ie_d = 1'b0;
    end else
`endif
    if (psw_wr) begin
      {ie_d, v_d, n_d, z_d, c_d} = psw_din[4:0];
`ifdef PSW_SHADOW_EN
      if (psw_din[WIDTH-1]) stk_err_d = 1'b0;
`endif
    end else if (setc || clrc) begin
      // Both high cancel out; flag_we still owns Z/N/V here.
      if (setc && !clrc) c_d = 1'b1;
      if (clrc && !setc) c_d = 1'b0;
      if (flag_we) begin
        if (flag_mask[1]) z_d = alu_z;
        if (flag_mask[2]) n_d = alu_n;
        if (flag_mask[3]) v_d = alu_v;
      end
    end else if (flag_we) begin
      if (flag_mask[0]) c_d = alu_c;
      if (flag_mask[1]) z_d = alu_z;
      if (flag_mask[2]) n_d = alu_n;
      if (flag_mask[3]) v_d = alu_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q  <= 1'b0;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
      v_q  <= 1'b0;
      ie_q <= 1'b0;
    end else begin
      c_q  <= c_d;
      z_q  <= z_d;
      n_q  <= n_d;
      v_q  <= v_d;
      ie_q <= ie_d;
    end
  end

`ifdef PSW_SHADOW_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stk_cnt_q <= 3'd0;
      stk_err_q <= 1'b0;
    end else begin
      stk_cnt_q <= stk_cnt_d;
      stk_err_q <= stk_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_en) stk_q[push_idx] <= psw_cur;
  end

  assign stk_cnt = stk_cnt_q;
  assign stk_err = stk_err_q;
`else
  logic unused_cur;
  assign unused_cur = ^psw_cur;
  assign stk_cnt    = 3'd0;
  assign stk_err    = 1'b0;
`endif

  assign PSW_C    = c_q;
  assign PSW_Z    = z_q;
  assign PSW_N    = n_q;
  assign PSW_V    = v_q;
  assign PSW_IE   = ie_q;
  assign psw_dout = {{(WIDTH-5){1'b0}}, psw_cur};

endmodule

// File: tb/tb_psw_flag_unit.sv
// tb/tb_psw_flag_unit.sv - directed self-checking bench for psw_flag_unit
// Shadow-stack vectors run when PSW_SHADOW_EN is defined; otherwise the tied-off behaviour is checked.
module tb_psw_flag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Sum;
  logic        Cout, A_msb, B_msb, ALUop, flag_we;
  logic [3:0]  flag_mask;
  logic        psw_wr;
  logic [15:0] psw_din;
  logic        setc, clrc, int_save, int_restore;
  logic        PSW_C, PSW_Z, PSW_N, PSW_V, PSW_IE;
  logic [15:0] psw_dout;
  logic [2:0]  stk_cnt;
  logic        stk_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  psw_flag_unit #(.WIDTH(16), .STK_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .Sum(Sum), .Cout(Cout), .A_msb(A_msb), .B_msb(B_msb),
    .ALUop(ALUop), .flag_we(flag_we), .flag_mask(flag_mask), .psw_wr(psw_wr),
    .psw_din(psw_din), .setc(setc), .clrc(clrc), .int_save(int_save),
    .int_restore(int_restore), .PSW_C(PSW_C), .PSW_Z(PSW_Z), .PSW_N(PSW_N),
    .PSW_V(PSW_V), .PSW_IE(PSW_IE), .psw_dout(psw_dout), .stk_cnt(stk_cnt),
    .stk_err(stk_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; Sum = '0; Cout = 1'b0; A_msb = 1'b0; B_msb = 1'b0; ALUop = 1'b0;
    flag_we = 1'b0; flag_mask = 4'h0; psw_wr = 1'b0; psw_din = '0;
    setc = 1'b0; clrc = 1'b0; int_save = 1'b0; int_restore = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic alu(input logic [15:0] s, input logic co, input logic a, input logic b,
                     input logic op, input logic [3:0] m);
    Sum = s; Cout = co; A_msb = a; B_msb = b; ALUop = op; flag_we = 1'b1; flag_mask = m;
  endtask

  task automatic load(input logic [15:0] d);
    psw_wr = 1'b1; psw_din = d;
    step();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    check("reset_dout", psw_dout, 0);
    check("reset_cnt", stk_cnt, 0);
    check("reset_err", stk_err, 0);

    alu(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    step();
    check("add_ovf_C", PSW_C, 0);
    check("add_ovf_Z", PSW_Z, 0);
    check("add_ovf_N", PSW_N, 1);
    check("add_ovf_V", PSW_V, 1);
    check("add_ovf_dout", psw_dout, 16'h000C);

    alu(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF);
    step();
    check("sub_eq_dout", psw_dout, 16'h0003);

    alu(16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1);
    step();
    check("mask_c_only", psw_dout, 16'h0002);

    alu(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    setc = 1'b1;
    step();
    check("setc_with_we", psw_dout, 16'h000D);

    setc = 1'b1; clrc = 1'b1;
    step();
    check("setc_clrc_hold", psw_dout, 16'h000D);

    clrc = 1'b1;
    step();
    check("clrc", psw_dout, 16'h000C);

    alu(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
    psw_wr = 1'b1; psw_din = 16'hFFF1;
    step();
    check("wr_beats_we", psw_dout, 16'h0011);

`ifdef PSW_SHADOW_EN
    int_save = 1'b1;
    step();
    check("save1_dout", psw_dout, 16'h0001);
    check("save1_cnt", stk_cnt, 1);
    load(16'h0016);
    int_save = 1'b1;
    step();
    check("save2_dout", psw_dout, 16'h0006);
    check("save2_cnt", stk_cnt, 2);
    int_save = 1'b1;
    step();
    check("save_full_cnt", stk_cnt, 2);
    check("save_full_err", stk_err, 1);
    check("save_full_ie", PSW_IE, 0);
    int_restore = 1'b1;
    step();
    check("pop1_dout", psw_dout, 16'h0016);
    check("pop1_cnt", stk_cnt, 1);
    int_restore = 1'b1;
    step();
    check("pop2_dout", psw_dout, 16'h0011);
    check("pop2_cnt", stk_cnt, 0);
    int_restore = 1'b1;
    step();
    check("pop_empty_dout", psw_dout, 16'h0011);
    check("pop_empty_cnt", stk_cnt, 0);
    check("pop_empty_err", stk_err, 1);

    load(16'h8000);
    check("err_clear", stk_err, 0);
    check("err_clear_dout", psw_dout, 16'h0000);

    load(16'h0013);
    int_save = 1'b1;
    step();
    int_save = 1'b1; int_restore = 1'b1;
    step();
    check("save_restore_dout", psw_dout, 16'h0013);
    check("save_restore_cnt", stk_cnt, 0);
    check("save_restore_err", stk_err, 0);

    load(16'h001F);
    int_save = 1'b1;
    step();
    check("pre_rst_cnt", stk_cnt, 1);
`else
    int_save = 1'b1;
    step();
    check("nostk_save_dout", psw_dout, 16'h0001);
    check("nostk_save_cnt", stk_cnt, 0);
    check("nostk_save_err", stk_err, 0);
    load(16'h0013);
    int_restore = 1'b1;
    step();
    check("nostk_restore", psw_dout, 16'h0013);
    check("nostk_restore_cnt", stk_cnt, 0);
    int_save = 1'b1;
    step();
    check("nostk_save2_err", stk_err, 0);
`endif

    alu(16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
    rst = 1'b1; int_save = 1'b1;
    step();
    check("mid_rst_dout", psw_dout, 0);
    check("mid_rst_C", PSW_C, 0);
    check("mid_rst_cnt", stk_cnt, 0);
    check("mid_rst_err", stk_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
